// File: rtl/decoder_scan_sequencer.sv
// Index sequencer for a 3-to-8 decoder: sweeps sel 0..7 or 7..0, holding each
// index for dwell+1 cycles, in single-sweep or continuous mode.
module decoder_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               mode_cont_i,
    input  logic               dir_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [2:0]         sel_o,
    output logic               sel_en_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               wrap_o
);

    typedef enum logic {IDLE, SCAN} state_e;

    state_e             state_q;
    logic [2:0]         sel_q;
    logic               sel_en_q, busy_q, done_q, wrap_q;
    logic [DWELL_W-1:0] cnt_q, dwell_q;
    logic               dir_q, cont_q;

    logic [2:0] first_d, restart_d, step_d;
    logic       last_idx_d, dwell_end_d;

    always_comb begin
        first_d     = dir_i ? 3'd7 : 3'd0;
        restart_d   = dir_q ? 3'd7 : 3'd0;
        step_d      = dir_q ? (sel_q - 3'd1) : (sel_q + 3'd1);
        last_idx_d  = (sel_q == (dir_q ? 3'd0 : 3'd7));
        // Compare before incrementing so the counter can never overflow.
        dwell_end_d = (cnt_q >= dwell_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= 3'd0;
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            cnt_q    <= '0;
            dwell_q  <= '0;
            dir_q    <= 1'b0;
            cont_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && !stop_i) begin
                        state_q  <= SCAN;
                        dwell_q  <= dwell_i;
                        dir_q    <= dir_i;
                        cont_q   <= mode_cont_i;
                        sel_q    <= first_d;
                        cnt_q    <= '0;
                        sel_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (stop_i) begin
                        state_q  <= IDLE;
                        sel_q    <= 3'd0;
                        sel_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (!dwell_end_d) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                        if (!last_idx_d) begin
                            sel_q <= step_d;
                        end else if (cont_q) begin
                            sel_q  <= restart_d;
                            wrap_q <= 1'b1;
                        end else begin
                            state_q  <= IDLE;
                            sel_q    <= 3'd0;
                            sel_en_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel_o    = sel_q;
    assign sel_en_o = sel_en_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign wrap_o   = wrap_q;

endmodule
